// File: rtl/rdl_subreg_pkg.sv
// Shared types for the generated register-block support logic.
// The read responder tracks its response buffer fill level with rd_occ_e.
package rdl_subreg_pkg;

   typedef enum logic [1:0] {
      OccEmpty,
      OccOne,
      OccFull
   } rd_occ_e;

endpackage

// File: rtl/rdl_rd_fifo2.sv
// Two-entry in-order FIFO holding {err, data} read responses.
// All storage clears on reset, so the head reads as zero while the block is reset.
module rdl_rd_fifo2
   import rdl_subreg_pkg::*;
#(
   parameter int W = 33
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         push,
   input  logic [W-1:0] push_data,
   input  logic         pop,
   output logic [W-1:0] head,
   output rd_occ_e      occ
);

   logic [W-1:0] mem_reg [2];
   logic         wr_ptr_reg;
   logic         rd_ptr_reg;
   rd_occ_e      occ_reg;
   rd_occ_e      occ_next;
   logic         push_ok;
   logic         pop_ok;

   // Guard against overflow/underflow so the pointers can never desynchronise.
   assign push_ok = push && (occ_reg != OccFull);
   assign pop_ok  = pop && (occ_reg != OccEmpty);

   always_comb begin
      occ_next = occ_reg;
      case (occ_reg)
         OccEmpty: if (push_ok) occ_next = OccOne;
         OccOne: begin
            if (push_ok && !pop_ok)      occ_next = OccFull;
            else if (pop_ok && !push_ok) occ_next = OccEmpty;
         end
         OccFull:  if (pop_ok) occ_next = OccOne;
         default:  occ_next = OccEmpty;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         mem_reg[0] <= '0;
         mem_reg[1] <= '0;
         wr_ptr_reg <= 1'b0;
         rd_ptr_reg <= 1'b0;
         occ_reg    <= OccEmpty;
      end else begin
         if (push_ok) begin
            mem_reg[wr_ptr_reg] <= push_data;
            wr_ptr_reg          <= ~wr_ptr_reg;
         end
         if (pop_ok) rd_ptr_reg <= ~rd_ptr_reg;
         occ_reg <= occ_next;
      end
   end

   assign head = mem_reg[rd_ptr_reg];
   assign occ  = occ_reg;

endmodule

// File: rtl/rdl_reg_rd_resp.sv
// Read-side responder: decodes word reads, pulses read side-effect strobes and
// returns {err, data} through a two-entry buffered valid/ready channel.
module rdl_reg_rd_resp
   import rdl_subreg_pkg::*;
#(
   parameter int DW      = 32,
   parameter int NumRegs = 8,
   parameter int AW      = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic [AW-1:0]         req_addr,
   input  logic [NumRegs*DW-1:0] reg_rdata,
   output logic [NumRegs-1:0]    reg_rd_strobe,
   output logic                  rsp_valid,
   input  logic                  rsp_ready,
   output logic [DW-1:0]         rsp_data,
   output logic                  rsp_err
);

   logic          acc;
   logic          in_range;
   logic          pop;
   logic [DW-1:0] rd_word;
   logic [DW-1:0] reg_word [NumRegs];
   logic [DW:0]   push_data;
   logic [DW:0]   head;
   rd_occ_e       occ;

   // req_ready depends only on buffer state, never on rsp_ready.
   assign req_ready = !rst && (occ != OccFull);
   assign acc       = req_valid && req_ready;
   assign in_range  = 32'(req_addr) < 32'(NumRegs);
   assign rsp_valid = (occ != OccEmpty);
   assign pop       = rsp_valid && rsp_ready;

   generate
      for (genvar gi = 0; gi < NumRegs; gi++) begin : g_reg
         assign reg_word[gi]      = reg_rdata[gi*DW +: DW];
         assign reg_rd_strobe[gi] = acc && (32'(req_addr) == gi);
      end
   endgenerate

   always_comb begin
      rd_word = '0;
      for (int i = 0; i < NumRegs; i++) begin
         if (32'(req_addr) == i) rd_word = reg_word[i];
      end
   end

   // Out-of-range reads return zero data with the error flag set.
   assign push_data = in_range ? {1'b0, rd_word} : {1'b1, {DW{1'b0}}};

   rdl_rd_fifo2 #(
      .W (DW + 1)
   ) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (acc),
      .push_data (push_data),
      .pop       (pop),
      .head      (head),
      .occ       (occ)
   );

   assign rsp_data = head[DW-1:0];
   assign rsp_err  = head[DW];

endmodule

// File: tb/tb_rdl_reg_rd_resp.sv
// Directed bench for rdl_reg_rd_resp: table of per-cycle vectors plus
// hand-written streaming, read-to-clear and reset-while-full sequences.
module tb_rdl_reg_rd_resp;

   localparam int DW = 32;
   localparam int NR = 8;
   localparam int AW = 4;

   logic           clk;
   logic           rst;
   logic           req_valid;
   logic           req_ready;
   logic [AW-1:0]  req_addr;
   logic [NR*DW-1:0] reg_rdata;
   logic [NR-1:0]  reg_rd_strobe;
   logic           rsp_valid;
   logic           rsp_ready;
   logic [DW-1:0]  rsp_data;
   logic           rsp_err;

   logic           rtc_en;
   logic           rtc_load;
   logic [DW-1:0]  rtc_val;

   int checks;
   int failures;

   typedef struct {
      logic          rv;
      logic [3:0]    addr;
      logic          rr;
      logic          x_rdy;
      logic [7:0]    x_stb;
      logic          x_vld;
      logic [31:0]   x_data;
      logic          x_err;
   } vec_t;

   vec_t vecs[17];

   rdl_reg_rd_resp #(
      .DW      (DW),
      .NumRegs (NR),
      .AW      (AW)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .req_valid     (req_valid),
      .req_ready     (req_ready),
      .req_addr      (req_addr),
      .reg_rdata     (reg_rdata),
      .reg_rd_strobe (reg_rd_strobe),
      .rsp_valid     (rsp_valid),
      .rsp_ready     (rsp_ready),
      .rsp_data      (rsp_data),
      .rsp_err       (rsp_err)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   function automatic logic [31:0] regval(int i);
      return 32'hA5A5_0000 | 32'(i);
   endfunction

   // Register 5 can be switched to a read-to-clear model.
   always_comb begin
      reg_rdata = '0;
      for (int i = 0; i < NR; i++) begin
         if (i == 5 && rtc_en) reg_rdata[i*DW +: DW] = rtc_val;
         else                  reg_rdata[i*DW +: DW] = regval(i);
      end
   end

   always @(posedge clk) begin
      if (rtc_load)                         rtc_val <= 32'h0000_00FF;
      else if (rtc_en && reg_rd_strobe[5])  rtc_val <= '0;
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   // Drive inputs 1 time unit after a rising edge; sample 3 units later.
   task automatic drive(input logic rv, input logic [3:0] addr, input logic rr);
      @(posedge clk);
      #1;
      req_valid = rv;
      req_addr  = addr;
      rsp_ready = rr;
      #3;
   endtask

   initial begin
      checks    = 0;
      failures  = 0;
      rst       = 1'b1;
      req_valid = 1'b1;
      req_addr  = 4'd3;
      rsp_ready = 1'b0;
      rtc_en    = 1'b0;
      rtc_load  = 1'b0;

      //            rv    addr  rr    rdy   stb     vld   data           err
      vecs[0]  = '{1'b1, 4'd3, 1'b1, 1'b1, 8'h08, 1'b0, 32'h0,        1'b0};
      vecs[1]  = '{1'b0, 4'd0, 1'b1, 1'b1, 8'h00, 1'b1, 32'hA5A5_0003, 1'b0};
      vecs[2]  = '{1'b1, 4'd9, 1'b1, 1'b1, 8'h00, 1'b0, 32'h0,        1'b0};
      vecs[3]  = '{1'b0, 4'd0, 1'b1, 1'b1, 8'h00, 1'b1, 32'h0,        1'b1};
      vecs[4]  = '{1'b1, 4'd1, 1'b0, 1'b1, 8'h02, 1'b0, 32'h0,        1'b0};
      vecs[5]  = '{1'b1, 4'd2, 1'b0, 1'b1, 8'h04, 1'b1, 32'hA5A5_0001, 1'b0};
      vecs[6]  = '{1'b1, 4'd4, 1'b0, 1'b0, 8'h00, 1'b1, 32'hA5A5_0001, 1'b0};
      vecs[7]  = '{1'b0, 4'd0, 1'b1, 1'b0, 8'h00, 1'b1, 32'hA5A5_0001, 1'b0};
      vecs[8]  = '{1'b0, 4'd0, 1'b0, 1'b1, 8'h00, 1'b1, 32'hA5A5_0002, 1'b0};
      vecs[9]  = '{1'b0, 4'd0, 1'b0, 1'b1, 8'h00, 1'b1, 32'hA5A5_0002, 1'b0};
      vecs[10] = '{1'b0, 4'd0, 1'b1, 1'b1, 8'h00, 1'b1, 32'hA5A5_0002, 1'b0};
      vecs[11] = '{1'b0, 4'd0, 1'b0, 1'b1, 8'h00, 1'b0, 32'h0,        1'b0};
      vecs[12] = '{1'b1, 4'd6, 1'b0, 1'b1, 8'h40, 1'b0, 32'h0,        1'b0};
      vecs[13] = '{1'b1, 4'd7, 1'b1, 1'b1, 8'h80, 1'b1, 32'hA5A5_0006, 1'b0};
      vecs[14] = '{1'b0, 4'd0, 1'b0, 1'b1, 8'h00, 1'b1, 32'hA5A5_0007, 1'b0};
      vecs[15] = '{1'b0, 4'd0, 1'b1, 1'b1, 8'h00, 1'b1, 32'hA5A5_0007, 1'b0};
      vecs[16] = '{1'b0, 4'd0, 1'b1, 1'b1, 8'h00, 1'b0, 32'h0,        1'b0};

      // Reset state, with a request pending that must not be accepted.
      @(posedge clk);
      @(posedge clk);
      #4;
      chk("rst_req_ready", 32'(req_ready), 32'd0);
      chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
      chk("rst_strobe", 32'(reg_rd_strobe), 32'd0);
      chk("rst_rsp_data", rsp_data, 32'd0);
      chk("rst_rsp_err", 32'(rsp_err), 32'd0);

      @(posedge clk);
      #1;
      rst       = 1'b0;
      req_valid = 1'b0;
      #3;
      chk("rel_req_ready", 32'(req_ready), 32'd1);
      chk("rel_rsp_valid", 32'(rsp_valid), 32'd0);

      for (int v = 0; v < 17; v++) begin
         drive(vecs[v].rv, vecs[v].addr, vecs[v].rr);
         $display("vec %0d: rv=%0d addr=%0d rr=%0d -> rdy=%0d stb=%02h vld=%0d data=%08h err=%0d",
                  v, vecs[v].rv, vecs[v].addr, vecs[v].rr, req_ready, reg_rd_strobe,
                  rsp_valid, rsp_data, rsp_err);
         chk($sformatf("vec%0d_req_ready", v), 32'(req_ready), 32'(vecs[v].x_rdy));
         chk($sformatf("vec%0d_strobe", v), 32'(reg_rd_strobe), 32'(vecs[v].x_stb));
         chk($sformatf("vec%0d_rsp_valid", v), 32'(rsp_valid), 32'(vecs[v].x_vld));
         if (vecs[v].x_vld) begin
            chk($sformatf("vec%0d_rsp_data", v), rsp_data, vecs[v].x_data);
            chk($sformatf("vec%0d_rsp_err", v), 32'(rsp_err), 32'(vecs[v].x_err));
         end
      end

      // Streaming 0..7 with rsp_ready high: one response per cycle.
      for (int i = 0; i < NR; i++) begin
         drive(1'b1, 4'(i), 1'b1);
         $display("stream %0d: rdy=%0d stb=%02h vld=%0d data=%08h",
                  i, req_ready, reg_rd_strobe, rsp_valid, rsp_data);
         chk($sformatf("stream%0d_req_ready", i), 32'(req_ready), 32'd1);
         chk($sformatf("stream%0d_strobe", i), 32'(reg_rd_strobe), 32'd1 << i);
         if (i > 0) begin
            chk($sformatf("stream%0d_rsp_valid", i), 32'(rsp_valid), 32'd1);
            chk($sformatf("stream%0d_rsp_data", i), rsp_data, regval(i - 1));
         end
      end
      drive(1'b0, 4'd0, 1'b1);
      chk("stream_last_valid", 32'(rsp_valid), 32'd1);
      chk("stream_last_data", rsp_data, regval(7));
      drive(1'b0, 4'd0, 1'b1);
      chk("stream_drained", 32'(rsp_valid), 32'd0);

      // Read-to-clear: first read returns 0xFF, the immediate second read 0.
      @(posedge clk);
      #1;
      rtc_load = 1'b1;
      @(posedge clk);
      #1;
      rtc_load = 1'b0;
      rtc_en   = 1'b1;
      #3;
      drive(1'b1, 4'd5, 1'b1);
      chk("rtc_strobe1", 32'(reg_rd_strobe), 32'h20);
      drive(1'b1, 4'd5, 1'b1);
      $display("rtc read1: vld=%0d data=%08h", rsp_valid, rsp_data);
      chk("rtc_strobe2", 32'(reg_rd_strobe), 32'h20);
      chk("rtc_first_data", rsp_data, 32'h0000_00FF);
      drive(1'b0, 4'd0, 1'b1);
      $display("rtc read2: vld=%0d data=%08h", rsp_valid, rsp_data);
      chk("rtc_second_valid", 32'(rsp_valid), 32'd1);
      chk("rtc_second_data", rsp_data, 32'd0);
      drive(1'b0, 4'd0, 1'b1);
      rtc_en = 1'b0;

      // Fill the buffer, then reset mid-cycle while stalled.
      drive(1'b1, 4'd1, 1'b0);
      drive(1'b1, 4'd2, 1'b0);
      drive(1'b0, 4'd0, 1'b0);
      chk("full_req_ready", 32'(req_ready), 32'd0);
      chk("full_rsp_valid", 32'(rsp_valid), 32'd1);
      req_valid = 1'b1;
      req_addr  = 4'd3;
      rst       = 1'b1;
      #1;
      $display("async rst: vld=%0d rdy=%0d data=%08h", rsp_valid, req_ready, rsp_data);
      chk("arst_rsp_valid", 32'(rsp_valid), 32'd0);
      chk("arst_req_ready", 32'(req_ready), 32'd0);
      chk("arst_rsp_data", rsp_data, 32'd0);
      chk("arst_strobe", 32'(reg_rd_strobe), 32'd0);
      @(posedge clk);
      #1;
      rst       = 1'b0;
      req_valid = 1'b0;
      rsp_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         #3;
         chk($sformatf("post_rst%0d_valid", i), 32'(rsp_valid), 32'd0);
         chk($sformatf("post_rst%0d_req_ready", i), 32'(req_ready), 32'd1);
         @(posedge clk);
         #1;
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
